matrix_stream_collector: RTL and testbench
==========================================

Name: matrix_stream_collector

Overview:
- Receiving end of the serial output interface of the 4x4 complex matrix multiplier.
- Consumes the element stream on Serial_Matrix_Out_r/_i, qualified by valid and done, and reassembles it into a full 4x4 complex matrix in row-major order.
- Presents the matrix on flat parallel buses with a valid/ack handshake, so a result can feed a following stage, such as the next multiplication or a writeback block.
- Detects framing and overflow errors on the stream.

Parameters:
- INTEGER_SIZE, 7, integer bits of the signed fixed-point element.
- FRACT_SIZE, 11, fractional bits.
- DATA_WIDTH, 18, total element width; must equal INTEGER_SIZE+FRACT_SIZE.
- N, 4, matrix dimension; frame length is N*N = 16 elements.

Ports:
- clk  in  1  Rising-edge clock.
- rst_n  in  1  Asynchronous active-low reset.
- in_r  in  DATA_WIDTH  Serial element, real part.
- in_i  in  DATA_WIDTH  Serial element, imaginary part.
- in_valid  in  1  Element present this cycle.
- in_done  in  1  Asserted with the last element of a frame.
- mat_r  out  N*N*DATA_WIDTH  Real parts; element (row,col) at slice index row*N+col, with index 0 in the LSBs.
- mat_i  out  N*N*DATA_WIDTH  Imaginary parts; same layout as mat_r.
- mat_valid  out  1  A complete matrix is held on mat_r/mat_i.
- mat_ack  in  1  Consumer has taken the matrix.
- frame_err  out  1  Sticky flag: in_done arrived with a count other than 16.
- ovf_err  out  1  Sticky flag: an element arrived while the matrix was held and not released.
- err_clr  in  1  Clears both sticky error flags.

Behaviour:
Reset (asynchronous, rst_n=0):
- All outputs go to 0: mat_r, mat_i, mat_valid, frame_err, ovf_err.
- Element counter goes to 0; state goes to COLLECT.

State COLLECT:
- Each cycle with in_valid=1 writes in_r/in_i into slot[cnt], then cnt increments.
- Writes occur at the clock edge; no other slot changes.
- cnt is log2(N*N) bits wide.
- Element accepted with in_done=1 and cnt==15:
  - Go to FULL, cnt returns to 0.
  - mat_valid is 1 in the following cycle, giving 1-cycle latency from the last accepted element.
- Element accepted with in_done=1 and cnt!=15:
  - The element is written, then the frame is discarded.
  - frame_err set, cnt returns to 0, stay in COLLECT, mat_valid stays 0.
- Element accepted with in_done=0 and cnt==15:
  - frame_err set, cnt wraps to 0, stay in COLLECT.
- in_done with in_valid=0 is ignored.

State FULL:
- mat_valid=1 and mat_r/mat_i are stable.
- mat_ack=1:
  - Next state is COLLECT and mat_valid drops the next cycle.
  - If in_valid=1 in the same cycle, that element is accepted as slot 0 of the next frame (cnt becomes 1). Slot 0 of the outgoing matrix is overwritten at that edge, which is legal because the consumer sampled it at that same edge.
- mat_ack=0 with in_valid=1:
  - The element is dropped and ovf_err is set.
  - Slots and cnt are unchanged.
- mat_ack while not in FULL is ignored.

Error flags:
- err_clr=1 clears both flags at the next edge.
- If a set condition and err_clr occur in the same cycle, the set wins.
- Flags do not affect data flow.

Data handling: elements are stored bit-exact, with no arithmetic or sign handling.

Reset mid-frame: any partial frame is lost and the held matrix is cleared to 0.

Decomposition:
- Shared package (mat_pkg) holds INTEGER_SIZE, FRACT_SIZE, DATA_WIDTH and N defaults, the frame length constant N*N, and the state encoding (COLLECT, FULL).
- One natural sub-module: frame_counter.
  - Holds the modulo-N*N counter.
  - Outputs: is_last (cnt==N*N-1) and the current index.
- The storage array and the FSM stay in the top module.

Test Plan:
1. Normal frame:
   - Stimulus: 16 back-to-back elements in_r=k, in_i=0x3FFFF-k (k=0..15), in_done on k=15.
   - Required: mat_valid=1 exactly one cycle after the last element; slice k of mat_r equals k; slice 15 of mat_i equals 0x3FFF0; no error flags.
2. Gapped stream:
   - Stimulus: same 16 elements with in_valid toggling 1/0 each cycle.
   - Required: identical matrix to scenario 1; mat_valid rises only after the 16th valid element.
3. Hold and overflow:
   - Stimulus: after a completed frame, hold mat_ack=0 and drive 3 elements of 0x00046.
   - Required: ovf_err=1; matrix unchanged; mat_valid stays 1.
   - Then pulse err_clr: ovf_err returns to 0.
4. Ack with same-cycle element:
   - Stimulus: mat_ack=1 with in_valid=1 and in_r=0x3FD90.
   - Required: next cycle mat_valid=0, slot 0 of mat_r equals 0x3FD90, cnt=1; the next 15 elements complete a new frame.
5. Framing errors:
   - Stimulus: in_done asserted on the 10th element.
   - Required: frame_err=1, mat_valid stays 0, and the next 16-element frame is captured correctly.
   - Stimulus: 16 elements with no in_done.
   - Required: frame_err=1.
6. Reset mid-frame:
   - Stimulus: rst_n=0 asynchronously after 7 elements.
   - Required: all outputs 0 immediately, before the next clock edge; a following full frame is captured correctly with no errors.

Source files
------------

// File: rtl/mat_pkg.sv
// mat_pkg: shared defaults and state encoding for the matrix stream collector
package mat_pkg;

    localparam int MAT_INTEGER_SIZE = 7;
    localparam int MAT_FRACT_SIZE   = 11;
    localparam int MAT_DATA_WIDTH   = MAT_INTEGER_SIZE + MAT_FRACT_SIZE;
    localparam int MAT_N            = 4;
    localparam int FRAME_LEN        = MAT_N * MAT_N;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

endpackage

// File: rtl/frame_counter.sv
// frame_counter: modulo N*N element index with last-slot flag
module frame_counter #(
    parameter int N  = 4,
    parameter int CW = $clog2(N * N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] idx,
    output logic          is_last
);

    localparam logic [CW-1:0] LAST = CW'(N * N - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Clear beats increment; the last slot wraps back to zero
    always_comb begin
        cnt_d = clr ? '0 : inc ? (cnt_q == LAST ? '0 : cnt_q + 1'b1) : cnt_q;
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign idx     = cnt_q;
    assign is_last = (cnt_q == LAST);

endmodule

// File: rtl/matrix_stream_collector.sv
// matrix_stream_collector: reassembles a serial complex element stream into a held 4x4 matrix
module matrix_stream_collector
    import mat_pkg::*;
#(
    parameter int INTEGER_SIZE = MAT_INTEGER_SIZE,
    parameter int FRACT_SIZE   = MAT_FRACT_SIZE,
    parameter int DATA_WIDTH   = INTEGER_SIZE + FRACT_SIZE,
    parameter int N            = MAT_N
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_WIDTH-1:0]       in_r,
    input  logic [DATA_WIDTH-1:0]       in_i,
    input  logic                        in_valid,
    input  logic                        in_done,
    output logic [N*N*DATA_WIDTH-1:0]   mat_r,
    output logic [N*N*DATA_WIDTH-1:0]   mat_i,
    output logic                        mat_valid,
    input  logic                        mat_ack,
    output logic                        frame_err,
    output logic                        ovf_err,
    input  logic                        err_clr
);

    localparam int CW = $clog2(N * N);

    logic [CW-1:0] idx;
    logic          is_last;
    logic          accept;
    logic          done_ok;

    state_t state_q, state_d;
    logic   mat_valid_q;
    logic   frame_err_q, frame_err_d;
    logic   ovf_err_q, ovf_err_d;

    logic [N*N-1:0][DATA_WIDTH-1:0] mat_r_q, mat_r_d;
    logic [N*N-1:0][DATA_WIDTH-1:0] mat_i_q, mat_i_d;

    frame_counter #(.N(N), .CW(CW)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (accept),
        .clr     (accept && in_done),
        .idx     (idx),
        .is_last (is_last)
    );

    // Acceptance, next state and sticky error flags (a set outranks err_clr)
    always_comb begin
        accept      = in_valid && (state_q == COLLECT || mat_ack);
        done_ok     = accept && in_done && is_last;
        state_d     = done_ok ? FULL : (state_q == FULL && !mat_ack) ? FULL : COLLECT;
        frame_err_d = (accept && (in_done != is_last)) || (frame_err_q && !err_clr);
        ovf_err_d   = (state_q == FULL && !mat_ack && in_valid) || (ovf_err_q && !err_clr);
    end

    // Slot write: only the slot addressed by the counter changes
    always_comb begin
        mat_r_d = mat_r_q;
        mat_i_d = mat_i_q;
        if (accept) begin
            mat_r_d[idx] = in_r;
            mat_i_d[idx] = in_i;
        end
    end

    // FSM with registered valid and error outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            mat_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mat_valid_q <= (state_d == FULL);
            frame_err_q <= frame_err_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    // Matrix storage, cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_r_q <= '0;
            mat_i_q <= '0;
        end else begin
            mat_r_q <= mat_r_d;
            mat_i_q <= mat_i_d;
        end
    end

    assign mat_r     = mat_r_q;
    assign mat_i     = mat_i_q;
    assign mat_valid = mat_valid_q;
    assign frame_err = frame_err_q;
    assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_matrix_stream_collector.sv
// tb_matrix_stream_collector: scoreboard bench for the matrix stream collector
module tb_matrix_stream_collector;

    localparam int DW = 18;
    localparam int N  = 4;
    localparam int NE = N * N;

    typedef logic [NE*DW-1:0] flat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_r = '0;
    logic [DW-1:0] in_i = '0;
    logic          in_valid = 1'b0;
    logic          in_done = 1'b0;
    flat_t         mat_r;
    flat_t         mat_i;
    logic          mat_valid;
    logic          mat_ack = 1'b0;
    logic          frame_err;
    logic          ovf_err;
    logic          err_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    flat_t exp_r_q[$];
    flat_t exp_i_q[$];

    matrix_stream_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_r      (in_r),
        .in_i      (in_i),
        .in_valid  (in_valid),
        .in_done   (in_done),
        .mat_r     (mat_r),
        .mat_i     (mat_i),
        .mat_valid (mat_valid),
        .mat_ack   (mat_ack),
        .frame_err (frame_err),
        .ovf_err   (ovf_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives elements first..last of (r,i); done on the last one; optional idle gap after each
    task automatic send(input flat_t r, input flat_t i, input int first, input int last,
                        input bit done_at_end, input bit gap);
        for (int k = first; k <= last; k++) begin
            in_valid = 1'b1;
            in_r     = r[k*DW +: DW];
            in_i     = i[k*DW +: DW];
            in_done  = done_at_end && (k == last);
            if (k == last && done_at_end) begin
                n_cmp++;
                if (mat_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL early_valid: mat_valid=%b required 0 before last element", mat_valid);
                end
            end
            step();
            in_valid = 1'b0;
            in_done  = 1'b0;
            if (gap && k != last) step();
        end
    endtask

    // Pops the expected matrix once mat_valid shows, bounded by a cycle budget
    task automatic check_matrix(input string name);
        flat_t er, ei;
        int waited = 0;
        while (mat_valid !== 1'b1 && waited < 8) begin
            step();
            waited++;
        end
        n_cmp++;
        if (mat_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_valid_timeout: mat_valid=%b required 1", name, mat_valid);
            return;
        end
        if (exp_r_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s_scoreboard_empty: matrix seen with nothing expected", name);
            return;
        end
        er = exp_r_q.pop_front();
        ei = exp_i_q.pop_front();
        n_cmp++;
        if (mat_r !== er) begin
            n_bad++;
            $display("FAIL %s_mat_r: got %h required %h", name, mat_r, er);
        end
        n_cmp++;
        if (mat_i !== ei) begin
            n_bad++;
            $display("FAIL %s_mat_i: got %h required %h", name, mat_i, ei);
        end
    endtask

    task automatic ack();
        mat_ack = 1'b1;
        step();
        mat_ack = 1'b0;
        n_cmp++;
        if (mat_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_drop: mat_valid=%b required 0", mat_valid);
        end
    endtask

    task automatic check_flags(input string name, input logic fe, input logic oe);
        n_cmp++;
        if (frame_err !== fe || ovf_err !== oe) begin
            n_bad++;
            $display("FAIL %s_flags: frame_err=%b ovf_err=%b required %b %b", name, frame_err, ovf_err, fe, oe);
        end
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    function automatic void make_ramp(output flat_t r, output flat_t i);
        for (int k = 0; k < NE; k++) begin
            r[k*DW +: DW] = DW'(k);
            i[k*DW +: DW] = DW'(18'h3FFFF - k);
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if (mat_r !== '0 || mat_i !== '0 || mat_valid !== 1'b0 || frame_err !== 1'b0 || ovf_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: valid=%b fe=%b oe=%b mat_r=%h required all 0", mat_valid, frame_err, ovf_err, mat_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_normal();
        flat_t r, i;
        make_ramp(r, i);
        exp_r_q.push_back(r);
        exp_i_q.push_back(i);
        send(r, i, 0, NE - 1, 1'b1, 1'b0);
        n_cmp++;
        if (mat_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL normal_latency: mat_valid=%b required 1 one cycle after last element", mat_valid);
        end
        n_cmp++;
        if (mat_r[5*DW +: DW] !== 18'd5 || mat_i[15*DW +: DW] !== 18'h3FFF0) begin
            n_bad++;
            $display("FAIL normal_slices: r5=%h i15=%h required 00005 3fff0", mat_r[5*DW +: DW], mat_i[15*DW +: DW]);
        end
        check_matrix("normal");
        check_flags("normal", 1'b0, 1'b0);
        ack();
    endtask

    task automatic test_gapped();
        flat_t r, i;
        make_ramp(r, i);
        exp_r_q.push_back(r);
        exp_i_q.push_back(i);
        send(r, i, 0, NE - 1, 1'b1, 1'b1);
        n_cmp++;
        if (mat_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL gapped_latency: mat_valid=%b required 1", mat_valid);
        end
        check_matrix("gapped");
        check_flags("gapped", 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        flat_t r, i;
        make_ramp(r, i);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_r = 18'h00046;
            in_i = 18'h00046;
            step();
        end
        in_valid = 1'b0;
        check_flags("ovf_set", 1'b0, 1'b1);
        n_cmp++;
        if (mat_valid !== 1'b1 || mat_r !== r || mat_i !== i) begin
            n_bad++;
            $display("FAIL ovf_hold: valid=%b mat_r=%h required 1 %h", mat_valid, mat_r, r);
        end
        clear_errs();
        check_flags("ovf_clr", 1'b0, 1'b0);
    endtask

    task automatic test_ack_same_cycle();
        flat_t r, i;
        for (int k = 0; k < NE; k++) begin
            r[k*DW +: DW] = DW'(18'h01000 + k);
            i[k*DW +: DW] = DW'(18'h20000 + 3 * k);
        end
        r[0 +: DW] = 18'h3FD90;
        exp_r_q.push_back(r);
        exp_i_q.push_back(i);
        mat_ack  = 1'b1;
        in_valid = 1'b1;
        in_r     = r[0 +: DW];
        in_i     = i[0 +: DW];
        step();
        mat_ack  = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (mat_valid !== 1'b0 || mat_r[0 +: DW] !== 18'h3FD90) begin
            n_bad++;
            $display("FAIL ack_same_cycle: valid=%b slot0=%h required 0 3fd90", mat_valid, mat_r[0 +: DW]);
        end
        send(r, i, 1, NE - 1, 1'b1, 1'b0);
        check_matrix("ack_same");
        check_flags("ack_same", 1'b0, 1'b0);
        ack();
    endtask

    task automatic test_framing();
        flat_t r, i;
        for (int k = 0; k < NE; k++) begin
            r[k*DW +: DW] = DW'(18'h2A000 ^ (k << 4));
            i[k*DW +: DW] = DW'(18'h15555 + k);
        end
        send(r, i, 0, 9, 1'b1, 1'b0);
        check_flags("short_frame", 1'b1, 1'b0);
        step();
        n_cmp++;
        if (mat_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL short_frame_valid: mat_valid=%b required 0", mat_valid);
        end
        clear_errs();
        exp_r_q.push_back(r);
        exp_i_q.push_back(i);
        send(r, i, 0, NE - 1, 1'b1, 1'b0);
        check_matrix("after_short");
        check_flags("after_short", 1'b0, 1'b0);
        ack();
        send(r, i, 0, NE - 1, 1'b0, 1'b0);
        check_flags("no_done", 1'b1, 1'b0);
        n_cmp++;
        if (mat_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL no_done_valid: mat_valid=%b required 0", mat_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        flat_t r, i;
        for (int k = 0; k < NE; k++) begin
            r[k*DW +: DW] = DW'($urandom);
            i[k*DW +: DW] = DW'($urandom);
        end
        send(r, i, 0, 6, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mat_r !== '0 || mat_i !== '0 || mat_valid !== 1'b0 || frame_err !== 1'b0 || ovf_err !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: valid=%b fe=%b oe=%b mat_r=%h required all 0", mat_valid, frame_err, ovf_err, mat_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        exp_r_q.push_back(r);
        exp_i_q.push_back(i);
        send(r, i, 0, NE - 1, 1'b1, 1'b0);
        check_matrix("post_reset");
        check_flags("post_reset", 1'b0, 1'b0);
        ack();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_gapped();
        test_overflow();
        test_ack_same_cycle();
        test_framing();
        test_reset_mid_frame();
        n_cmp++;
        if (exp_r_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover: %0d matrices never seen, required 0", exp_r_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
